memory_arbiter_rr: RTL and testbench



---
 rtl/memory_arbiter_rr.sv | 170 +++++++++++++++++
 tb/tb_memory_arbiter_rr.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter_rr.sv
// Round-robin arbiter of NCH cache-side request channels onto one registered RAM port.
// Latency: grant at the IDLE edge, RAM enables the cycle after; ack (cwait low) the cycle after ACCESS/ERROR.
// Backpressure: a requester holds its request until cwait drops; RAM stalls by reporting FREE/BUSY.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   cren/cwen           per-channel read/write request (write wins on the same channel)
//   caddr/cstore        per-channel address / write data
//   cload               per-channel read data, registered
//   cwait/cerr          per-channel "not yet complete" / one-cycle completion-with-error pulse
//   ramREN/ramWEN/ramaddr/ramstore  registered RAM request
//   ramload/ramstate    RAM read data / status (FREE=0 BUSY=1 ACCESS=2 ERROR=3)
//
// Optional build macro MEMARB_TIMEOUT_EN: abort an ISSUE that lasts TIMEOUT cycles,
// completing it with an error pulse.
module memory_arbiter_rr #(
    parameter int NCH     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NCH-1:0]          cren,
    input  logic [NCH-1:0]          cwen,
    input  logic [NCH-1:0][AW-1:0]  caddr,
    input  logic [NCH-1:0][DW-1:0]  cstore,
    output logic [NCH-1:0][DW-1:0]  cload,
    output logic [NCH-1:0]          cwait,
    output logic [NCH-1:0]          cerr,
    output logic                    ramREN,
    output logic                    ramWEN,
    output logic [AW-1:0]           ramaddr,
    output logic [DW-1:0]           ramstore,
    input  logic [DW-1:0]           ramload,
    input  logic [1:0]              ramstate
);

    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   rr;        // first channel to consider at the next grant
    logic [GW-1:0]   gnt;       // channel owning the current transaction
    logic [GW-1:0]   sel;
    logic [GW-1:0]   gnt_inc;
    logic [GW:0]     cand;
    logic [NCH-1:0]  req;
    logic            any_req;
    logic            err_q;     // current transaction ends with an error
    logic            tmo_hit;

    assign req     = cren | cwen;
    assign gnt_inc = (gnt == GW'(NCH - 1)) ? '0 : gnt + GW'(1);

    // Scan channels starting at rr and wrapping; the extra bit of cand
    // keeps rr+k from overflowing before the modulo-NCH fold.
    always_comb begin
        sel     = rr;
        any_req = 1'b0;
        cand    = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = {1'b0, rr} + (GW + 1)'(k);
            if (cand >= (GW + 1)'(NCH))
                cand = cand - (GW + 1)'(NCH);
            if (!any_req && req[cand[GW-1:0]]) begin
                any_req = 1'b1;
                sel     = cand[GW-1:0];
            end
        end
    end

`ifdef MEMARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            tmo_cnt <= '0;
        else if (state == IDLE)
            tmo_cnt <= '0;
        else if (state == ISSUE)
            tmo_cnt <= tmo_cnt + 16'd1;
    end

    // True during the TIMEOUT-th ISSUE cycle.
    assign tmo_hit = (state == ISSUE) && (tmo_cnt == 16'(TIMEOUT - 1));
`else
    // Without the watchdog an ISSUE waits on the RAM indefinitely.
    localparam int unused_timeout = TIMEOUT;
    assign tmo_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   if (ramstate == ST_ACCESS || ramstate == ST_ERROR || tmo_hit)
                         state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: the granted channel is acknowledged only in DONE
    always_comb begin
        cwait = req;
        cerr  = '0;
        if (state == DONE) begin
            cwait[gnt] = 1'b0;
            cerr[gnt]  = err_q;
        end
    end

    // Registered RAM request, read-data capture and pointer update
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr       <= '0;
            gnt      <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            cload    <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt      <= sel;
                        ramaddr  <= caddr[sel];
                        ramstore <= cstore[sel];
                        ramWEN   <= cwen[sel];
                        ramREN   <= cren[sel] & ~cwen[sel];
                    end else begin
                        ramREN   <= 1'b0;
                        ramWEN   <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (state_nxt == DONE) begin
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        // ACCESS beats a simultaneous timeout; everything else is an error.
                        err_q  <= (ramstate != ST_ACCESS);
                        // Driven by the latched op, so read data lands even if the
                        // requester has already dropped its request.
                        if (ramstate == ST_ACCESS && ramREN)
                            cload[gnt] <= ramload;
                    end
                end
                DONE: rr <= gnt_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// Directed bench for memory_arbiter_rr (NCH=4) with a small behavioural RAM.
// Latency: zero-wait RAM acks two negedges after the request is driven in IDLE.
// Backpressure: RAM mode selects ACCESS, BUSY (stall) or ERROR responses.
module tb_memory_arbiter_rr;

    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic                   CLK = 1'b0;
    logic                   RST;
    logic [NCH-1:0]         cren, cwen;
    logic [NCH-1:0][AW-1:0] caddr;
    logic [NCH-1:0][DW-1:0] cstore;
    logic [NCH-1:0][DW-1:0] cload;
    logic [NCH-1:0]         cwait, cerr;
    logic                   ramREN, ramWEN;
    logic [AW-1:0]          ramaddr;
    logic [DW-1:0]          ramstore;
    logic [DW-1:0]          ramload;
    logic [1:0]             ramstate;

    int n_chk = 0;
    int n_err = 0;
    int ram_mode;            // 0 zero-wait ACCESS, 1 BUSY forever, 2 ERROR

    logic [31:0] mem [16];
    logic [15:0] mem_v = '0;

    memory_arbiter_rr #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST),
        .cren(cren), .cwen(cwen), .caddr(caddr), .cstore(cstore),
        .cload(cload), .cwait(cwait), .cerr(cerr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    // RAM: unwritten words read as a fixed pattern (0x4 -> DEADBEEF, else C0DE000a)
    always_comb begin
        ramstate = 2'd0;
        if (ramREN || ramWEN) begin
            case (ram_mode)
                0:       ramstate = 2'd2;
                1:       ramstate = 2'd1;
                default: ramstate = 2'd3;
            endcase
        end
    end

    always_comb begin
        if (mem_v[ramaddr[3:0]])
            ramload = mem[ramaddr[3:0]];
        else if (ramaddr[3:0] == 4'h4)
            ramload = 32'hDEADBEEF;
        else
            ramload = 32'hC0DE0000 | {28'h0, ramaddr[3:0]};
    end

    always @(posedge CLK) begin
        if (ramWEN && ramstate == 2'd2) begin
            mem[ramaddr[3:0]]   <= ramstore;
            mem_v[ramaddr[3:0]] <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Read on one channel; returns negedges until cwait dropped (capped at bound)
    // and cerr at that point, then releases and idles one cycle.
    task automatic xact(input int ch, input logic [31:0] a, input int bound,
                        output int lat, output logic err);
        cren[ch]  = 1'b1;
        caddr[ch] = a;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (cwait[ch] && lat < bound);
        err = cerr[ch];
        cren[ch] = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        int   lat;
        logic err;
        int   ch;

        RST = 1'b1; cren = '0; cwen = '0; caddr = '0; cstore = '0; ram_mode = 0;
        cren[1] = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_ren",   ramREN,   0);
        chk("rst_wen",   ramWEN,   0);
        chk("rst_addr",  ramaddr,  0);
        chk("rst_store", ramstore, 0);
        chk("rst_cload", cload,    0);
        chk("rst_cerr",  cerr,     0);
        chk("rst_cwait", cwait,    4'b0010);
        cren[1] = 1'b0;
        RST = 1'b0;
        @(negedge CLK);

        // Single read ch0 @0x4
        cren[0] = 1'b1; caddr[0] = 32'h4;
        @(negedge CLK);
        chk("rd_ren",  ramREN,  1);
        chk("rd_addr", ramaddr, 32'h4);
        chk("rd_wait", cwait,   4'b0001);
        @(negedge CLK);
        chk("rd_ack",   cwait,    0);
        chk("rd_data",  cload[0], 32'hDEADBEEF);
        chk("rd_enoff", ramREN,   0);
        cren[0] = 1'b0;
        @(negedge CLK);

        // Write ch1 with cren+cwen together: write only
        cren[1] = 1'b1; cwen[1] = 1'b1; caddr[1] = 32'h0; cstore[1] = 32'h0ABCDEF9;
        @(negedge CLK);
        chk("wr_wen",   ramWEN,   1);
        chk("wr_ren",   ramREN,   0);
        chk("wr_store", ramstore, 32'h0ABCDEF9);
        @(negedge CLK);
        chk("wr_ack",     cwait[1], 0);
        chk("wr_nocload", cload[1], 0);
        cren[1] = 1'b0; cwen[1] = 1'b0;
        @(negedge CLK);
        xact(1, 32'h0, 50, lat, err);
        chk("rdbk_lat",  lat,      2);
        chk("rdbk_data", cload[1], 32'h0ABCDEF9);

        // ERROR on ch2 read
        ram_mode = 2;
        xact(2, 32'h5, 50, lat, err);
        chk("err_lat",   lat,      2);
        chk("err_cerr",  err,      1);
        chk("err_cload", cload[2], 0);
        chk("err_pulse", cerr,     0);
        ram_mode = 0;

        // rr now 3: ch3 beats ch0
        cren[0] = 1'b1; caddr[0] = 32'h1;
        cren[3] = 1'b1; caddr[3] = 32'h3;
        @(negedge CLK);
        chk("rr_grant3", ramaddr, 32'h3);
        @(negedge CLK);
        chk("rr_ack3", cwait, 4'b0001);
        cren[3] = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rr_grant0", ramaddr, 32'h1);
        @(negedge CLK);
        chk("rr_ack0",  cwait,    0);
        chk("rr_data0", cload[0], 32'hC0DE0001);
        cren[0] = 1'b0;
        @(negedge CLK);

        // Reset in the middle of a stalled ISSUE
        ram_mode = 1;
        cren[2] = 1'b1; caddr[2] = 32'h6;
        @(negedge CLK);
        chk("mid_ren", ramREN, 1);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_ren",   ramREN, 0);
        chk("mid_rst_cload", cload,  0);
        chk("mid_rst_cwait", cwait,  4'b0100);
        @(negedge CLK);
        RST = 1'b0; ram_mode = 0;
        xact(2, 32'h6, 50, lat, err);
        chk("mid_reissue_lat",  lat,      2);
        chk("mid_reissue_data", cload[2], 32'hC0DE0006);

        // Fairness from rr=0 with all channels requesting continuously
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            cren[i]  = 1'b1;
            caddr[i] = 32'(8 + i);
        end
        for (int t = 0; t < 5; t++) begin
            lat = 0;
            do begin
                @(negedge CLK);
                lat++;
            end while (cwait == 4'hF && lat < 20);
            ch = -1;
            for (int i = 0; i < NCH; i++)
                if (!cwait[i]) ch = i;
            chk("fair_lat", lat, (t == 0) ? 2 : 3);
            chk("fair_ch",  ch,  t % NCH);
            if (ch >= 0)
                chk("fair_data", cload[ch], 32'hC0DE0008 + 32'(ch));
        end
        cren = '0;
        repeat (2) @(negedge CLK);

        // RAM held BUSY
        ram_mode = 1;
        xact(1, 32'h2, 40, lat, err);
`ifdef MEMARB_TIMEOUT_EN
        chk("tmo_lat",   lat,      9);
        chk("tmo_cerr",  err,      1);
        chk("tmo_cload", cload[1], 32'hC0DE0009);
`else
        chk("busy_lat",  lat,      40);
        chk("busy_cerr", err,      0);
        chk("busy_ren",  ramREN,   1);
`endif
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        ram_mode = 0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
